// File: rtl/simple_cpu.sv
// -----------------------------------------------------------------------------
// simple_cpu
//
// Single-cycle processor core. It has 8-bit data, a 32-bit program counter and
// eight 8-bit registers. Each instruction is fetched from external instruction
// memory at PC and retires on the next rising clock edge.
//
// Ports
//   PC          out 32  address of the current instruction (PC register)
//   INSTRUCTION in  32  instruction word at PC (combinational from memory)
//   CLK         in   1  clock, rising edge
//   RESET       in   1  asynchronous reset, active high
//
// Instruction word
//   [31:24] opcode  [23:16] rd / branch offset  [15:8] rt  [7:0] rs / imm
//
// Build option
//   SIMPLE_CPU_EXT_ISA_EN : defined   -> bne, sll, srl, sra and ror are decoded
//                           undefined -> opcodes 8-12 act as NOPs and the
//                                        shifter is not built
// -----------------------------------------------------------------------------
module simple_cpu (
  output logic [31:0] PC,
  input  logic [31:0] INSTRUCTION,
  input  logic        CLK,
  input  logic        RESET
);

  localparam logic [7:0] OP_ADD   = 8'd0;
  localparam logic [7:0] OP_SUB   = 8'd1;
  localparam logic [7:0] OP_AND   = 8'd2;
  localparam logic [7:0] OP_OR    = 8'd3;
  localparam logic [7:0] OP_J     = 8'd4;
  localparam logic [7:0] OP_BEQ   = 8'd5;
  localparam logic [7:0] OP_MOV   = 8'd6;
  localparam logic [7:0] OP_LOADI = 8'd7;
`ifdef SIMPLE_CPU_EXT_ISA_EN
  localparam logic [7:0] OP_BNE   = 8'd8;
  localparam logic [7:0] OP_SLL   = 8'd9;
  localparam logic [7:0] OP_SRL   = 8'd10;
  localparam logic [7:0] OP_SRA   = 8'd11;
  localparam logic [7:0] OP_ROR   = 8'd12;
`endif

  logic [7:0]  regs [8];

  logic [7:0]  opcode;
  logic [7:0]  rd_field;
  logic [7:0]  imm;
  logic [2:0]  rd_idx;
  logic [2:0]  rt_idx;
  logic [2:0]  rs_idx;
  logic [7:0]  rt_val;
  logic [7:0]  rs_val;

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] pc_next;
  logic        take_branch;
  logic        wr_en;
  logic [7:0]  wr_data;

  // Only the low three bits of the rt field select a register.
  logic        unused_rt_hi;
  assign unused_rt_hi = ^INSTRUCTION[15:11];

  assign opcode   = INSTRUCTION[31:24];
  assign rd_field = INSTRUCTION[23:16];
  assign imm      = INSTRUCTION[7:0];
  assign rd_idx   = INSTRUCTION[18:16];
  assign rt_idx   = INSTRUCTION[10:8];
  assign rs_idx   = INSTRUCTION[2:0];

  // Read ports see the register array directly, so a value written on the
  // previous edge is already visible to the current instruction.
  assign rt_val = regs[rt_idx];
  assign rs_val = regs[rs_idx];

  assign pc_plus4      = PC + 32'd4;
  // The offset is a signed word count. Sign-extend it, then scale by 4.
  assign branch_target = pc_plus4 + {{22{rd_field[7]}}, rd_field, 2'b00};

`ifdef SIMPLE_CPU_EXT_ISA_EN
  logic        amt_big;
  logic [7:0]  sll_res;
  logic [7:0]  srl_res;
  logic [7:0]  sra_res;
  logic [15:0] ror_tmp;
  logic [7:0]  ror_res;

  // Shift amounts of 8 or more flush the operand. Rotate ignores this
  // because it uses the amount modulo 8.
  assign amt_big = (imm[7:3] != 5'd0);
  assign sll_res = amt_big ? 8'd0 : (rt_val << imm[2:0]);
  assign srl_res = amt_big ? 8'd0 : (rt_val >> imm[2:0]);
  assign sra_res = amt_big ? {8{rt_val[7]}} : 8'($signed(rt_val) >>> imm[2:0]);
  assign ror_tmp = {rt_val, rt_val} >> imm[2:0];
  assign ror_res = ror_tmp[7:0];
`endif

  always_comb begin
    take_branch = 1'b0;
    wr_en       = 1'b0;
    wr_data     = 8'd0;
    case (opcode)
      OP_ADD:   begin wr_en = 1'b1; wr_data = rt_val + rs_val; end
      OP_SUB:   begin wr_en = 1'b1; wr_data = rt_val - rs_val; end
      OP_AND:   begin wr_en = 1'b1; wr_data = rt_val & rs_val; end
      OP_OR:    begin wr_en = 1'b1; wr_data = rt_val | rs_val; end
      OP_J:     take_branch = 1'b1;
      OP_BEQ:   take_branch = (rt_val == rs_val);
      OP_MOV:   begin wr_en = 1'b1; wr_data = rs_val; end
      OP_LOADI: begin wr_en = 1'b1; wr_data = imm; end
`ifdef SIMPLE_CPU_EXT_ISA_EN
      OP_BNE:   take_branch = (rt_val != rs_val);
      OP_SLL:   begin wr_en = 1'b1; wr_data = sll_res; end
      OP_SRL:   begin wr_en = 1'b1; wr_data = srl_res; end
      OP_SRA:   begin wr_en = 1'b1; wr_data = sra_res; end
      OP_ROR:   begin wr_en = 1'b1; wr_data = ror_res; end
`endif
      default:  ;
    endcase
  end

  assign pc_next = take_branch ? branch_target : pc_plus4;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PC <= 32'd0;
      for (int i = 0; i < 8; i++) begin
        regs[i] <= 8'd0;
      end
    end else begin
      PC <= pc_next;
      if (wr_en) begin
        regs[rd_idx] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_simple_cpu.sv
module tb_simple_cpu;

  logic [31:0] PC;
  logic [31:0] INSTRUCTION;
  logic        CLK;
  logic        RESET;

  simple_cpu dut (
    .PC          (PC),
    .INSTRUCTION (INSTRUCTION),
    .CLK         (CLK),
    .RESET       (RESET)
  );

`ifdef SIMPLE_CPU_EXT_ISA_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  typedef struct {
    int          cyc;
    int          kind;   // 0: PC, 1: register
    int          idx;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          base  = 0;
  logic [31:0] imem [64];

  always_comb INSTRUCTION = imem[PC[7:2]];

  initial begin
    CLK = 1'b0;
    forever #4 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard monitor: check every expectation that falls due at this cycle.
  always @(negedge CLK) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      act = (e.kind == 0) ? PC : {24'd0, dut.regs[e.idx]};
      total++;
      if (e.cyc != cyc || act !== e.val) begin
        bad++;
        $display("FAIL %s: cyc=%0d due=%0d got=0x%08h want=0x%08h",
                 e.name, cyc, e.cyc, act, e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic push_pc(input int k, input logic [31:0] v, input string n);
    exp_t e;
    e = '{base + k, 0, 0, v, n};
    sb.push_back(e);
  endtask

  task automatic push_reg(input int k, input int r, input logic [7:0] v, input string n);
    exp_t e;
    e = '{base + k, 1, r, {24'd0, v}, n};
    sb.push_back(e);
  endtask

  // Hold reset across a clock edge and load a fresh program.
  task automatic enter_reset();
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    base  = cyc;
    for (int i = 0; i < 64; i++) imem[i] = 32'hFF00_0000;
  endtask

  task automatic leave_reset();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    base  = cyc;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge CLK);
  endtask

  initial begin
    RESET = 1'b1;
    for (int i = 0; i < 64; i++) imem[i] = 32'hFF00_0000;
    #5;

    // Program A: loadi and bne
    enter_reset();
    imem[0] = 32'h0704_0005;
    imem[1] = 32'h0705_0004;
    imem[2] = 32'h0801_0405;
    imem[3] = 32'h0707_0001;
    imem[4] = 32'h0707_0002;
    push_pc(0, 32'd0, "a_rst_pc");
    push_reg(0, 4, 8'd0, "a_rst_r4");
    push_reg(0, 7, 8'd0, "a_rst_r7");
    leave_reset();
    push_pc(1, 32'd4, "a_pc1");
    push_reg(1, 4, 8'd5, "a_loadi_r4");
    push_pc(2, 32'd8, "a_pc2");
    push_reg(2, 5, 8'd4, "a_loadi_r5");
    if (EXT) begin
      push_pc(3, 32'd16, "a_bne_taken_pc");
      push_reg(3, 7, 8'd0, "a_bne_r7_skip");
      push_pc(4, 32'd20, "a_pc4");
      push_reg(4, 7, 8'd2, "a_r7_final");
      push_pc(5, 32'd24, "a_pc5");
      push_reg(5, 7, 8'd2, "a_r7_hold");
    end else begin
      push_pc(3, 32'd12, "a_bne_nop_pc");
      push_reg(3, 7, 8'd0, "a_bne_nop_r7");
      push_pc(4, 32'd16, "a_pc4");
      push_reg(4, 7, 8'd1, "a_r7_first");
      push_pc(5, 32'd20, "a_pc5");
      push_reg(5, 7, 8'd2, "a_r7_final");
    end
    run(6);

    // Program B: shifts and rotates
    enter_reset();
    imem[0]  = 32'h0704_0005;
    imem[1]  = 32'h0905_0403;
    imem[2]  = 32'h0704_009A;
    imem[3]  = 32'h0A05_0405;
    imem[4]  = 32'h0B05_0404;
    imem[5]  = 32'h0704_0078;
    imem[6]  = 32'h0C05_0402;
    imem[7]  = 32'h0705_0000;
    imem[8]  = 32'h0C05_040A;
    imem[9]  = 32'h0905_0408;
    imem[10] = 32'h0704_009A;
    imem[11] = 32'h0B05_0409;
    imem[12] = 32'h0A05_04C8;
    leave_reset();
    push_reg(2,  5, EXT ? 8'h28 : 8'h00, "b_sll3");
    push_reg(4,  5, EXT ? 8'h04 : 8'h00, "b_srl5");
    push_reg(5,  5, EXT ? 8'hF9 : 8'h00, "b_sra4");
    push_reg(7,  5, EXT ? 8'h1E : 8'h00, "b_ror2");
    push_reg(8,  5, 8'h00,               "b_clr_r5");
    push_reg(9,  5, EXT ? 8'h1E : 8'h00, "b_ror10");
    push_reg(10, 5, 8'h00,               "b_sll8");
    push_reg(12, 5, EXT ? 8'hFF : 8'h00, "b_sra9");
    push_reg(13, 5, 8'h00,               "b_srl200");
    push_pc(13, 32'd52, "b_pc13");
    run(14);

    // Program C: arithmetic, beq, then asynchronous reset mid-cycle
    enter_reset();
    imem[0] = 32'h0701_00C8;
    imem[1] = 32'h0702_0064;
    imem[2] = 32'h0003_0102;
    imem[3] = 32'h0104_0201;
    imem[4] = 32'h0505_0102;
    imem[5] = 32'h05FE_0303;
    leave_reset();
    push_reg(1, 1, 8'd200, "c_r1");
    push_reg(2, 2, 8'd100, "c_r2");
    push_reg(3, 3, 8'd44,  "c_add_wrap");
    push_reg(4, 4, 8'd156, "c_sub_wrap");
    push_pc(5, 32'd20, "c_beq_not_taken");
    push_pc(6, 32'd16, "c_beq_back");
    push_pc(7, 32'd20, "c_pc7");
    run(8);
    #1;
    RESET = 1'b1;
    base  = cyc;
    push_pc(0, 32'd0, "c_async_pc");
    push_reg(0, 1, 8'd0, "c_async_r1");
    push_reg(0, 3, 8'd0, "c_async_r3");
    push_reg(0, 4, 8'd0, "c_async_r4");
    #1;
    total++;
    if (PC !== 32'd0) begin
      bad++;
      $display("FAIL c_async_pc_now: got=0x%08h want=0x00000000", PC);
    end
    total++;
    if (dut.regs[1] !== 8'd0) begin
      bad++;
      $display("FAIL c_async_r1_now: got=0x%02h want=0x00", dut.regs[1]);
    end
    total++;
    if (dut.regs[3] !== 8'd0) begin
      bad++;
      $display("FAIL c_async_r3_now: got=0x%02h want=0x00", dut.regs[3]);
    end
    total++;
    if (dut.regs[4] !== 8'd0) begin
      bad++;
      $display("FAIL c_async_r4_now: got=0x%02h want=0x00", dut.regs[4]);
    end
    @(negedge CLK);
    #1;
    RESET = 1'b0;
    base  = cyc;
    push_pc(1, 32'd4, "c_restart_pc");
    push_reg(1, 1, 8'd200, "c_restart_r1");
    run(2);

    // Program D: and/or/mov, jump forward, back-to-back writes, NOP opcode
    enter_reset();
    imem[0]  = 32'h0701_00C8;
    imem[1]  = 32'h0702_0064;
    imem[2]  = 32'h0203_0102;
    imem[3]  = 32'h0303_0102;
    imem[4]  = 32'h0606_0003;
    imem[5]  = 32'h0402_0000;
    imem[6]  = 32'h0707_0001;
    imem[7]  = 32'h0707_0002;
    imem[8]  = 32'h0707_0009;
    imem[9]  = 32'h0707_0003;
    imem[10] = 32'h0D07_0007;
    leave_reset();
    push_reg(3, 3, 8'h40, "d_and");
    push_reg(4, 3, 8'hEC, "d_or");
    push_reg(5, 6, 8'hEC, "d_mov_raw");
    push_pc(5, 32'd20, "d_pc5");
    push_pc(6, 32'd32, "d_jump_fwd");
    push_reg(6, 7, 8'd0, "d_jump_skip");
    push_reg(7, 7, 8'd9, "d_r7_first");
    push_reg(8, 7, 8'd3, "d_r7_last");
    push_pc(9, 32'd44, "d_nop_pc");
    push_reg(9, 7, 8'd3, "d_nop_r7");
    run(10);

    @(negedge CLK);
    #1;
    total++;
    if (dut.regs[7] !== 8'd3) begin
      bad++;
      $display("FAIL d_end_r7: got=0x%02h want=0x03", dut.regs[7]);
    end
    total++;
    if (dut.regs[1] !== 8'd200) begin
      bad++;
      $display("FAIL d_end_r1: got=0x%02h want=0xc8", dut.regs[1]);
    end
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL %s: never checked, due=%0d want=0x%08h", e.name, e.cyc, e.val);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simple_cpu.md
# simple_cpu

Single-cycle 8-bit-data processor core with a 32-bit program counter, an eight-entry 8-bit register file, an ALU with shift/rotate, and jump/branch control. It sits between an external byte-addressed instruction memory, which returns the little-endian word at PC, and the system clock/reset. Each instruction completes in one clock cycle. The extended-ISA opcodes (bne and the shifts) are compile-time optional.

## Interface
- Parameters: none.
- Module name `simple_cpu`.
- Port order: PC, INSTRUCTION, CLK, RESET.
- Clock and reset (already decided): one clock; reset is asynchronous and active-high.
- `CLK` — input, 1 bit. Single clock; all state updates on the rising edge.
- `RESET` — input, 1 bit. Asynchronous, active-high reset.
- `PC` — output, 32 bits. Address of the current instruction, driven directly from the PC register.
- `INSTRUCTION` — input, 32 bits. Instruction word at `PC`; combinational, arrives up to 2 time units after `PC` changes.

## Operation
- Instruction field layout:
  - [31:24] opcode.
  - [23:16] RD or branch/jump offset.
  - [15:8] RT (source 1).
  - [7:0] RS (source 2), immediate, or shift amount.
  - Register indices use bits [2:0] of the field.
- Opcodes:
  - 0 add: RD=RT+RS.
  - 1 sub: RD=RT−RS (two's complement, mod 256).
  - 2 and: RD=RT&RS.
  - 3 or: RD=RT|RS.
  - 4 j: PC=PC+4+(sext(offset)<<2); no register write.
  - 5 beq: if RT==RS then branch as j, else PC+4.
  - 6 mov: RD=RS.
  - 7 loadi: RD=imm[7:0].
  - 8 bne: if RT!=RS then branch as j, else PC+4.
  - 9 sll: RD=RT<<imm (zero fill).
  - 10 srl: RD=RT>>imm (zero fill).
  - 11 sra: RD=RT>>>imm (sign fill).
  - 12 ror: RD=RT rotated right by imm mod 8.
- Shift amounts ≥8:
  - sll/srl give 0.
  - sra gives 8 copies of bit 7.
- Arithmetic is 8-bit, wrap-around; carry and overflow are discarded.
- Branch offset is an 8-bit signed word count relative to PC+4; target addition is 32-bit, modulo 2^32.
- Opcodes 13–255 are NOPs: no register write, PC+4.
- The register file has two combinational read ports and one write port. Reading a register written by the previous instruction returns the new value.

## Timing
- Reset (asynchronous):
  - While RESET=1, PC=0 and all eight registers are 0.
  - Takes effect immediately, independent of CLK.
  - Mid-cycle reset discards the pending register write and branch.
- First instruction fetched from address 0 after RESET deasserts.
- Each rising CLK edge with RESET=0:
  - Commits the RD write, when the instruction writes.
  - Updates PC to the next address.
  - Both updates become visible 1 time unit after the edge.
- Latency: one cycle per instruction; no stalls or hazards.
- Combinational path (fetch 2 + decode + register read + ALU) must settle within an 8-time-unit clock period.
- Write to RD on the same edge that a later instruction reads it: the reader sees the value after the edge.
- Loading the same RD twice in consecutive cycles: the last write wins.

## Configuration
- `SIMPLE_CPU_EXT_ISA_EN`
  - Defined: opcodes 8–12 (bne, sll, srl, sra, ror) are implemented as specified.
  - Undefined: opcodes 8–12 decode as NOPs (PC+4, no write), and the shifter/rotator logic is omitted.

## Test plan
- Reset then loadi: RESET high 5 units → PC=0. `loadi r4,5` (0x07040005) → r4=5 after first edge; PC=4.
- bne taken (EXT on):
  - Program: `loadi r4,5`; `loadi r5,4`; `bne 1,r4,r5` (0x08010405) at PC 8; `loadi r7,1` at 12; `loadi r7,2` at 16.
  - Required: PC sequence 0,4,8,16,20; r7=2, never 1.
- sll/srl: r4=5, `sll r5,r4,3` (0x09050403) → r5=40. r4=154, `srl r5,r4,5` → r5=4.
- sra/ror:
  - r4=0x9A, `sra r5,r4,4` → r5=0xF9.
  - r4=0x78, `ror r5,r4,2` → r5=0x1E.
  - `ror` by 10 → same as `ror` by 2.
- Arithmetic/beq:
  - r1=200, r2=100: add → 44; sub r2−r1 → 156.
  - `beq` with offset −2 (0xFE) at PC 20 and equal operands → PC=16.
- Async reset mid-program: RESET pulsed between edges → PC=0 and all registers=0 immediately. Same bne program with macro undefined → PC sequence 0,4,8,12,16; r7=2.
